// File: rtl/shift_base3_encoder_pkg.sv
// Shared definitions for the base-3 shift-amount encoder: opcode encodings,
// FSM state type and the width of one base-3 digit.
package shift_pkg;

  // Width of a single base-3 digit (values 0..2 fit in two bits).
  localparam int DIGIT_W = 2;

  // Shift opcodes carried alongside the operand to the mux-array shifter.
  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROL = 2'd3;

  // Encoder FSM: waiting for a request, converting the amount, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/shift_base3_encoder_if.sv
// Request/result bundle between the upstream requester, the encoder and the
// base-3 shifter.
//
// Handshake rules (both sides): a transfer happens on a rising Clk edge where
// valid && ready are both high. The producer keeps valid and its payload
// stable until the transfer; the consumer may change ready freely. On the
// request side InReady is combinational from the encoder state and OutReady.
interface shift_base3_encoder_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);

  logic               InValid;
  logic               InReady;
  logic [WIDTH-1:0]   InData;
  logic [AMT_W-1:0]   InAmt;
  logic [1:0]         InOp;

  logic               OutValid;
  logic               OutReady;
  logic [WIDTH-1:0]   OutData;
  logic [1:0]         OutOp;
  logic [DIGIT_W-1:0] Base3_0;
  logic [DIGIT_W-1:0] Base3_1;
  logic [DIGIT_W-1:0] Base3_2;

  // Environment view: drives requests and the downstream ready.
  modport master (
    output InValid, InData, InAmt, InOp, OutReady,
    input  InReady, OutValid, OutData, OutOp, Base3_0, Base3_1, Base3_2
  );

  // Encoder view.
  modport slave (
    input  InValid, InData, InAmt, InOp, OutReady,
    output InReady, OutValid, OutData, OutOp, Base3_0, Base3_1, Base3_2
  );

endinterface

// File: rtl/shift_base3_encoder_div3_step.sv
// One divide-by-3 step: splits an unsigned value into quotient and remainder.
// Purely combinational; the encoder feeds its residue register through this
// once per conversion cycle.
module div3_step
  import shift_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic [AMT_W-1:0]   value,
  output logic [AMT_W-1:0]   quotient,
  output logic [DIGIT_W-1:0] remainder
);

  assign quotient  = value / AMT_W'(3);
  // A remainder mod 3 is always 0..2, so truncating to a digit loses nothing.
  assign remainder = DIGIT_W'(value % AMT_W'(3));

endmodule

// File: rtl/shift_base3_encoder.sv
// Front-end for the 16-bit base-3 mux-array shifter. Accepts operand, binary
// shift amount and opcode, converts the amount into DIGITS base-3 digits
// (least significant first) with an iterative divide-by-3, and holds the
// result until the shifter's consumer takes it.
//
// Build option SHIFT_FASTPATH_EN: amounts below 3 are already a single
// base-3 digit, so they skip the conversion and go straight to HOLD.
//
// DIGITS must satisfy 3**DIGITS > 2**AMT_W - 1 so every amount is
// representable; the three digit ports expose digits 0..2.
module shift_base3_encoder
  import shift_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int AMT_W  = 4,
  parameter int DIGITS = 3
) (
  input  logic                    Clk,
  input  logic                    Rst,
  shift_base3_encoder_if.slave    bus,
  output state_t                  dbg_state
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  state_t               state;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_op;
  logic [DIGIT_W-1:0]   digit [DIGITS];
  logic [AMT_W-1:0]     residue;
  logic [CNT_W-1:0]     cnt;

  logic                 in_ready;
  logic                 accept;
  logic [AMT_W-1:0]     div_q;
  logic [DIGIT_W-1:0]   div_r;

  // Single shared divider; the residue register walks it one digit per cycle.
  div3_step #(
    .AMT_W (AMT_W)
  ) u_div3_step (
    .value     (residue),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Ready to take a request when idle, or when the held result leaves this cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = bus.OutReady;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.InValid && in_ready;

  // Encoder FSM: accept latches the request, CONV peels one digit per cycle,
  // HOLD keeps everything stable until the downstream accepts.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      residue   <= '0;
      cnt       <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        digit[i] <= '0;
      end
    end else if (accept) begin
      // Covers both a fresh request from IDLE and a HOLD handoff.
      out_data <= bus.InData;
      out_op   <= bus.InOp;
      residue  <= bus.InAmt;
      cnt      <= '0;
`ifdef SHIFT_FASTPATH_EN
      if (bus.InAmt < AMT_W'(3)) begin
        digit[0] <= bus.InAmt[DIGIT_W-1:0];
        for (int i = 1; i < DIGITS; i++) begin
          digit[i] <= '0;
        end
        state     <= HOLD;
        out_valid <= 1'b1;
      end else begin
        state     <= CONV;
        out_valid <= 1'b0;
      end
`else
      state     <= CONV;
      out_valid <= 1'b0;
`endif
    end else begin
      case (state)
        CONV: begin
          digit[cnt] <= div_r;
          residue    <= div_q;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == LAST_DIGIT) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.OutReady) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.OutData  = out_data;
  assign bus.OutOp    = out_op;
  assign bus.Base3_0  = digit[0];
  assign bus.Base3_1  = digit[1];
  assign bus.Base3_2  = digit[2];
  assign dbg_state    = state;

endmodule

// File: tb/tb_shift_base3_encoder.sv
// Bench for shift_base3_encoder: directed requests, expected results pushed
// into a queue on accept, popped and compared by a separate output monitor.
module tb_shift_base3_encoder;
  import shift_pkg::*;

  // ---------------- clock / reset ----------------
  logic   Clk = 1'b0;
  logic   Rst = 1'b1;
  state_t dbg_state;
  int     cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  shift_base3_encoder_if #(.WIDTH(16), .AMT_W(4)) ifc ();

  shift_base3_encoder #(
    .WIDTH  (16),
    .AMT_W  (4),
    .DIGITS (3)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int   checks   = 0;
  int   errors   = 0;
  int   handoffs = 0;
  logic rand_ready = 1'b0;
  logic seen_front = 1'b0;

  // Entry: [43:28] accept cycle, [27:24] amt, [23:22] op, [21:6] data, [5:0] {d2,d1,d0}
  logic [43:0] exp_q[$];

  // Hand-computed base-3 digits {MSD, mid, LSD} for amounts 0..15.
  function automatic logic [5:0] dig_tab(input logic [3:0] a);
    case (a)
      4'd0:  return {2'd0, 2'd0, 2'd0};
      4'd1:  return {2'd0, 2'd0, 2'd1};
      4'd2:  return {2'd0, 2'd0, 2'd2};
      4'd3:  return {2'd0, 2'd1, 2'd0};
      4'd4:  return {2'd0, 2'd1, 2'd1};
      4'd5:  return {2'd0, 2'd1, 2'd2};
      4'd6:  return {2'd0, 2'd2, 2'd0};
      4'd7:  return {2'd0, 2'd2, 2'd1};
      4'd8:  return {2'd0, 2'd2, 2'd2};
      4'd9:  return {2'd1, 2'd0, 2'd0};
      4'd10: return {2'd1, 2'd0, 2'd1};
      4'd11: return {2'd1, 2'd0, 2'd2};
      4'd12: return {2'd1, 2'd1, 2'd0};
      4'd13: return {2'd1, 2'd1, 2'd1};
      4'd14: return {2'd1, 2'd1, 2'd2};
      default: return {2'd1, 2'd2, 2'd0};
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] a);
`ifdef SHIFT_FASTPATH_EN
    return (a < 4'd3) ? 1 : 4;
`else
    return (a == a) ? 4 : 4;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op);
    int n;
    n = 0;
    ifc.InValid = 1'b1;
    ifc.InData  = d;
    ifc.InAmt   = a;
    ifc.InOp    = op;
    @(negedge Clk);
    while (!(ifc.InReady && !Rst) && n < 60) begin
      @(negedge Clk);
      n++;
    end
    chk("send_accept_timeout", (n >= 60), 0);
    @(posedge Clk);
    #1;
    ifc.InValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_timeout", (n >= 200), 0);
    @(posedge Clk);
    #1;
  endtask

  // Random downstream stalls while enabled.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (rand_ready) ifc.OutReady = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard: record accepts ----------------
  always @(negedge Clk) begin
    if (Rst) begin
      exp_q.delete();
    end else if (ifc.InValid && ifc.InReady) begin
      exp_q.push_back({16'(cyc), ifc.InAmt, ifc.InOp, ifc.InData, dig_tab(ifc.InAmt)});
    end
  end

  // ---------------- scoreboard: output monitor ----------------
  always @(negedge Clk) begin
    logic [43:0] e;
    int          sum;
    if (Rst) begin
      seen_front = 1'b0;
    end else if (ifc.OutValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got valid with data 0x%0h, required no output", ifc.OutData);
      end else begin
        e = exp_q[0];
        if (!seen_front) begin
          chk("latency", 32'(cyc - int'(e[43:28])), 32'(exp_lat(e[27:24])));
          seen_front = 1'b1;
        end
        chk("out_data", 32'(ifc.OutData), 32'(e[21:6]));
        chk("out_op", 32'(ifc.OutOp), 32'(e[23:22]));
        chk("digits", 32'({ifc.Base3_2, ifc.Base3_1, ifc.Base3_0}), 32'(e[5:0]));
        chk("digit_range", 32'(ifc.Base3_0 <= 2'd2 && ifc.Base3_1 <= 2'd2 && ifc.Base3_2 <= 2'd2), 1);
        sum = 9 * int'(ifc.Base3_2) + 3 * int'(ifc.Base3_1) + int'(ifc.Base3_0);
        chk("digit_sum", 32'(sum), 32'(e[27:24]));
        if (!ifc.OutReady) begin
          chk("in_ready_stall", 32'(ifc.InReady), 0);
        end else begin
          void'(exp_q.pop_front());
          seen_front = 1'b0;
          if (ifc.InValid && ifc.InReady) handoffs++;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int h0;
    ifc.InValid  = 1'b0;
    ifc.InData   = '0;
    ifc.InAmt    = '0;
    ifc.InOp     = '0;
    ifc.OutReady = 1'b0;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_out_valid", 32'(ifc.OutValid), 0);
    chk("rst_out_data", 32'(ifc.OutData), 0);
    chk("rst_out_op", 32'(ifc.OutOp), 0);
    chk("rst_digits", 32'({ifc.Base3_2, ifc.Base3_1, ifc.Base3_0}), 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_in_ready", 32'(ifc.InReady), 1);

    // Amount 14 -> 1,1,2
    @(posedge Clk);
    #1;
    ifc.OutReady = 1'b1;
    send(16'h8001, 4'd14, OP_SRA);
    drain();

    // Amount 15 held under a 10-cycle stall -> 1,2,0
    ifc.OutReady = 1'b0;
    send(16'h0F0F, 4'd15, OP_ROL);
    repeat (14) @(posedge Clk);
    #1;
    ifc.OutReady = 1'b1;
    drain();

    // Back-to-back 5 then 9 with a HOLD handoff
    h0 = handoffs;
    send(16'hA5A5, 4'd5, OP_SLL);
    send(16'h5A5A, 4'd9, OP_SRL);
    drain();
    chk("b2b_handoff", 32'(handoffs - h0), 1);

    // Reset during CONV of amount 7: transaction dropped
    send(16'h1234, 4'd7, OP_SRL);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("midrst_out_valid", 32'(ifc.OutValid), 0);
    chk("midrst_digits", 32'({ifc.Base3_2, ifc.Base3_1, ifc.Base3_0}), 0);
    chk("midrst_in_ready", 32'(ifc.InReady), 1);
    chk("midrst_out_data", 32'(ifc.OutData), 0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    chk("midrst_queue", 32'(exp_q.size()), 0);
    repeat (8) @(posedge Clk);
    #1;

    // Rst and InValid together: nothing accepted
    Rst = 1'b1;
    ifc.InValid = 1'b1;
    ifc.InAmt   = 4'd4;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    ifc.InValid = 1'b0;
    @(negedge Clk);
    chk("rst_wins_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_wins_queue", 32'(exp_q.size()), 0);

    // Boundary amounts 0 and 2 (fast path when enabled)
    @(posedge Clk);
    #1;
    send(16'hFFFF, 4'd0, OP_SLL);
    drain();
    send(16'h0001, 4'd2, OP_SRA);
    drain();

    // Sweep 0..15 with random stalls
    rand_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      send(16'($urandom_range(0, 65535)), 4'(a), 2'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;
    ifc.OutReady = 1'b1;
    drain();

    chk("queue_empty_end", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global safety net.
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    errors++;
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_base3_encoder.md
Name: shift_base3_encoder

Overview:
- Front-end stage directly upstream of the 16-bit base-3 mux-array shifter.
- Accepts an operand, a binary shift amount and a shift opcode over a valid/ready handshake.
- Converts the amount to base-3 digits with an iterative divide-by-3 FSM, then holds operand, opcode and digits stable until the shifter's consumer accepts them.
- Every digit it emits is 0, 1 or 2, never 3, which satisfies the shifter's precondition.

Parameters:
- WIDTH, 16, operand width in bits.
- AMT_W, 4, binary shift-amount width.
- DIGITS, 3, number of base-3 digits; must satisfy 3^DIGITS > 2^AMT_W - 1.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Rst  in  1  reset; synchronous, active-high.
- InValid  in  1  upstream request valid.
- InReady  out  1  block can accept a request this cycle.
- InData  in  WIDTH  operand.
- InAmt  in  AMT_W  binary shift amount.
- InOp  in  2  opcode: 0=SLL, 1=SRL, 2=SRA, 3=ROL.
- OutValid  out  1  result valid toward the shifter.
- OutReady  in  1  downstream accepts the result.
- OutData  out  WIDTH  registered operand.
- OutOp  out  2  registered opcode.
- Base3_0, Base3_1, Base3_2  out  2 each  base-3 digits, least significant first.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Reset values: state=IDLE, OutValid=0, OutData=0, OutOp=0, all Base3_x=0, residue register=0, digit counter=0. InReady follows its equation after reset, so it reads 1 in IDLE.
- States:
  - IDLE: InReady=1, OutValid=0.
  - CONV: InReady=0, OutValid=0.
  - HOLD: InReady=OutReady, OutValid=1.
- Accept happens when InValid && InReady:
  - Latch InData and InOp into OutData and OutOp.
  - Load the residue register with InAmt.
  - Clear the digit counter.
  - Go to CONV.
- CONV, once per cycle:
  - Residue splits as q=residue/3, r=residue%3.
  - Write r into digit[counter], set residue=q, increment counter.
  - After the DIGITS-th write, go to HOLD.
- Latency: accept at cycle N gives OutValid=1 at cycle N+DIGITS+1, which is N+4 by default.
- HOLD:
  - OutData, OutOp and all digits stay stable while OutValid && !OutReady.
  - OutReady && !InValid: go to IDLE next cycle, OutValid=0.
  - OutReady && InValid: handoff and new accept in the same cycle; go straight to CONV. No bubble beyond the conversion cycles.
- Digits are written only in CONV. Base3_x change only after an accept.
- Arithmetic: unsigned throughout. Residue is AMT_W bits. Digit value is 0..2 by construction.
- Boundaries:
  - InAmt=0 yields all-zero digits.
  - InAmt=2^AMT_W-1 (15) yields 1,2,0 (MSD..LSD).
- Upstream rules:
  - InValid with InReady=0 is ignored. The upstream must hold its request.
  - Upstream signals are sampled only on the accept edge.
- Reset mid-operation (CONV or HOLD): the transaction is dropped, and all registers return to their reset values on the next edge.
- Rst and InValid asserted together: Rst wins and nothing is accepted.

Optional Feature:
- Macro: SHIFT_FASTPATH_EN.
- Defined:
  - An accept with InAmt<3 writes Base3_0=InAmt and Base3_1=Base3_2=0 directly.
  - The FSM goes straight to HOLD, so OutValid=1 at N+1.
  - Back-to-back accept from HOLD also takes the fast path.
- Undefined: all amounts take the full DIGITS-cycle conversion.

Decomposition:
- Package shift_pkg holds:
  - Opcode localparams OP_SLL, OP_SRL, OP_SRA, OP_ROL.
  - FSM state typedef (IDLE, CONV, HOLD).
  - Digit width constant 2.
- Sub-module div3_step: purely combinational. Input AMT_W-bit value; outputs quotient (AMT_W bits) and remainder (2 bits). Instantiated once and reused across CONV cycles.

Test Plan:
- Reset, then InAmt=14, InOp=2, InData=16'h8001, OutReady=1.
  -> OutValid at N+4; Base3_2=1, Base3_1=1, Base3_0=2; OutData=16'h8001; OutOp=2.
- InAmt=15 with OutReady held 0 for 10 cycles.
  -> digits 1,2,0 stable; OutValid=1 throughout; InReady=0 throughout.
- Two back-to-back requests, InAmt=5 then InAmt=9, with OutReady=1.
  -> second is accepted in the HOLD handoff cycle; results 0,1,2 then 1,0,0; no idle cycle between them.
- Rst pulsed during CONV of InAmt=7.
  -> next cycle OutValid=0, all digits 0, InReady=1; no output is ever produced for amount 7.
- InAmt=0 and InAmt=2, each with and without SHIFT_FASTPATH_EN.
  -> digits 0,0,0 and 0,0,2; latency N+1 when defined, N+4 when not.
- Sweep InAmt=0..15 with random OutReady stalls.
  -> every digit is <=2 and 9*Base3_2+3*Base3_1+Base3_0 equals InAmt.
